// File: rtl/adder_nibble_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit:
// FSM state encoding, operation encoding and the signed-overflow rule.
package adder_nibble_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: same-signed operands whose sum flips sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_nibble_seq_ctrl_if.sv
// Request/result bundle of the nibble-serial adder; bit 0 of a, b and s is the MSB.
interface adder_nibble_seq_ctrl_if #(
  parameter int WORD_WIDTH = 32
);

  logic                  start;
  logic                  op;
  logic [0:WORD_WIDTH-1] a;
  logic [0:WORD_WIDTH-1] b;
  logic                  inC;
  logic                  busy;
  logic                  done;
  logic [0:WORD_WIDTH-1] s;
  logic                  outC;
  logic                  ovl;

  modport master (
    output start, op, a, b, inC,
    input  busy, done, s, outC, ovl
  );

  modport slave (
    input  start, op, a, b, inC,
    output busy, done, s, outC, ovl
  );

endinterface

// File: rtl/adder_nibble_seq_ctrl_cla4.sv
// 4-bit carry-lookahead slice, reused once per nibble by the serial controller.
module Adder_CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       inC,
  output logic [3:0] s,
  output logic       outC
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms.
  assign c[0] = inC;
  assign c[1] = g[0] | (p[0] & inC);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & inC);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & inC);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & inC);

  assign s    = p ^ c[3:0];
  assign outC = c[4];

endmodule

// File: rtl/adder_nibble_seq_ctrl.sv
// Multi-cycle add/subtract: one CLA slice walks the operands a nibble per cycle,
// least significant nibble first, with the carry chained through a register.
module adder_nibble_seq_ctrl
  import adder_nibble_seq_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_nibble_seq_ctrl_if.slave  bus
);

  localparam int NIBBLES = WORD_WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES);

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         count_q;
  logic [0:WORD_WIDTH-1] op_a_q;
  logic [0:WORD_WIDTH-1] op_b_q;
  logic [0:WORD_WIDTH-1] s_q;
  logic                  carry_q;
  logic                  outc_q;
  logic                  ovl_q;

  logic                  accept;
  logic                  last;
  logic [CW-1:0]         nib;
  int                    nib_base;
  logic [3:0]            slice_a;
  logic [3:0]            slice_b;
  logic [3:0]            slice_s;
  logic                  slice_c;

  assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last   = (count_q == CW'(NIBBLES - 1));

  // Nibble k sits at bits [4k:4k+3]; the highest k holds the least significant bits.
  always_comb begin
    nib      = CW'(NIBBLES - 1) - count_q;
    nib_base = 4 * int'(nib);
    slice_a  = op_a_q[nib_base +: 4];
    slice_b  = op_b_q[nib_base +: 4];
  end

  Adder_CLA_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .inC  (carry_q),
    .s    (slice_s),
    .outC (slice_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Subtract is a + ~b + 1, so the inversion and forced carry happen at latch time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      outc_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else if (accept) begin
      count_q <= '0;
      op_a_q  <= bus.a;
      op_b_q  <= (bus.op == OP_ADD) ? bus.b : ~bus.b;
      carry_q <= (bus.op == OP_SUB) ? 1'b1 : bus.inC;
      s_q     <= '0;
      outc_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else if (state_q == ST_RUN) begin
      s_q[nib_base +: 4] <= slice_s;
      carry_q            <= slice_c;
      count_q            <= count_q + CW'(1);
      if (last) begin
        outc_q <= slice_c;
        ovl_q  <= signed_ovf(op_a_q[0], op_b_q[0], slice_s[3]);
      end
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.s    = s_q;
  assign bus.outC = outc_q;
  assign bus.ovl  = ovl_q;

endmodule
